// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr_if: bundle of handshake/bus signals for the N:1 stream mux.
//   in_data   : NCH*WIDTH producer data, channel i at [i*WIDTH +: WIDTH]
//   in_valid  : per-channel beat valid
//   in_last   : per-channel end-of-packet flag
//   in_ready  : per-channel beat accepted (driven by the mux)
//   sel       : requested channel for externally selected arbitration
//   out_data  : registered output data
//   out_valid : output beat valid
//   out_last  : output end-of-packet flag
//   out_ready : consumer accepts the output beat
//   grant     : channel currently locked
//   busy      : high while a packet is locked
// Modport slave is the mux's view; modport master is the surrounding
// producers/consumer.
interface stream_mux_rr_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
);
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_last;
    logic [NCH-1:0]       in_ready;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_last;
    logic                 out_ready;
    logic [SELW-1:0]      grant;
    logic                 busy;

    modport slave (
        input  in_data, in_valid, in_last, sel, out_ready,
        output in_ready, out_data, out_valid, out_last, grant, busy
    );

    modport master (
        output in_data, in_valid, in_last, sel, out_ready,
        input  in_ready, out_data, out_valid, out_last, grant, busy
    );
endinterface

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel stream multiplexer with packet locking.
// Arbitration is round-robin (MODE 0) or driven by bus.sel (MODE 1). A grant
// is held until a beat with in_last transfers. Output is a single register
// stage that can drain and load in the same cycle (1 beat/clk in a packet).
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : stream_mux_rr_if.slave (see interface file for signal list)
module stream_mux_rr #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2,
    parameter int MODE  = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    stream_mux_rr_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_r, state_nxt;
    logic [SELW-1:0]  grant_r, grant_nxt;
    logic [SELW-1:0]  last_grant_r, last_grant_nxt;
    logic             busy_r, busy_nxt;
    logic [WIDTH-1:0] out_data_r, out_data_nxt;
    logic             out_valid_r, out_valid_nxt;
    logic             out_last_r, out_last_nxt;

    logic             accept_s;
    logic             xfer_s;
    logic             cand_found_s;
    logic [SELW-1:0]  cand_s;
    logic [WIDTH-1:0] g_data_s;
    logic             g_valid_s;
    logic             g_last_s;
    logic [NCH-1:0]   in_ready_s;

    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_last  = out_last_r;
    assign bus.grant     = grant_r;
    assign bus.busy      = busy_r;
    assign bus.in_ready  = in_ready_s;

    // Candidate selection for the next arbitration.
    always_comb begin
        cand_found_s = 1'b0;
        cand_s       = {SELW{1'b0}};
        if (MODE == 0) begin
            // Descending distance so the channel nearest after last_grant
            // is written last and therefore wins.
            for (int k = NCH; k >= 1; k--) begin
                for (int i = 0; i < NCH; i++) begin
                    if ((((int'(last_grant_r) + k) % NCH) == i) && bus.in_valid[i]) begin
                        cand_found_s = 1'b1;
                        cand_s       = SELW'(i);
                    end else begin
                        cand_found_s = cand_found_s;
                        cand_s       = cand_s;
                    end
                end
            end
        end else begin
            // sel values >= NCH match no channel, so no grant is issued.
            for (int i = 0; i < NCH; i++) begin
                if ((bus.sel == SELW'(i)) && bus.in_valid[i]) begin
                    cand_found_s = 1'b1;
                    cand_s       = SELW'(i);
                end else begin
                    cand_found_s = cand_found_s;
                    cand_s       = cand_s;
                end
            end
        end
    end

    // Granted-channel data/valid/last mux and per-channel ready.
    always_comb begin
        g_data_s   = {WIDTH{1'b0}};
        g_valid_s  = 1'b0;
        g_last_s   = 1'b0;
        in_ready_s = {NCH{1'b0}};
        accept_s   = !out_valid_r || bus.out_ready;
        for (int i = 0; i < NCH; i++) begin
            g_data_s      = g_data_s | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_r == SELW'(i)}});
            g_valid_s     = g_valid_s | (bus.in_valid[i] & (grant_r == SELW'(i)));
            g_last_s      = g_last_s | (bus.in_last[i] & (grant_r == SELW'(i)));
            // Ready never looks at in_valid, only at lock state and output room.
            in_ready_s[i] = (state_r == LOCKED) && (grant_r == SELW'(i)) && accept_s;
        end
    end

    // Next-state and next-output computation.
    always_comb begin
        state_nxt      = state_r;
        grant_nxt      = grant_r;
        last_grant_nxt = last_grant_r;
        busy_nxt       = busy_r;
        out_data_nxt   = out_data_r;
        out_valid_nxt  = out_valid_r;
        out_last_nxt   = out_last_r;
        xfer_s         = (state_r == LOCKED) && g_valid_s && accept_s;

        case (state_r)
            IDLE: begin
                if (cand_found_s) begin
                    state_nxt = LOCKED;
                    grant_nxt = cand_s;
                    busy_nxt  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            LOCKED: begin
                if (xfer_s && g_last_s) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = grant_r;
                    busy_nxt       = 1'b0;
                end else begin
                    state_nxt = LOCKED;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase

        // Load wins over drain so a beat can leave and enter in one cycle.
        if (xfer_s) begin
            out_data_nxt  = g_data_s;
            out_last_nxt  = g_last_s;
            out_valid_nxt = 1'b1;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_nxt = 1'b0;
        end else begin
            out_valid_nxt = out_valid_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            grant_r      <= {SELW{1'b0}};
            last_grant_r <= SELW'(NCH - 1);
            busy_r       <= 1'b0;
            out_data_r   <= {WIDTH{1'b0}};
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt;
            grant_r      <= grant_nxt;
            last_grant_r <= last_grant_nxt;
            busy_r       <= busy_nxt;
            out_data_r   <= out_data_nxt;
            out_valid_r  <= out_valid_nxt;
            out_last_r   <= out_last_nxt;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed bench for stream_mux_rr. One MODE 0 instance
// (NCH=4, SELW=2) and one MODE 1 instance (NCH=4, SELW=3) share clk/rst_n.
module tb_stream_mux_rr;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    stream_mux_rr_if #(.WIDTH(8), .NCH(4), .SELW(2)) b0 ();
    stream_mux_rr_if #(.WIDTH(8), .NCH(4), .SELW(3)) b1 ();

    stream_mux_rr #(.WIDTH(8), .NCH(4), .SELW(2), .MODE(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    stream_mux_rr #(.WIDTH(8), .NCH(4), .SELW(3), .MODE(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        b0.in_data   = 32'h0;
        b0.in_valid  = 4'b0000;
        b0.in_last   = 4'b0000;
        b0.sel       = 2'd0;
        b0.out_ready = 1'b1;
        b1.in_data   = 32'h0;
        b1.in_valid  = 4'b0000;
        b1.in_last   = 4'b0000;
        b1.sel       = 3'd0;
        b1.out_ready = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", b0.out_valid); end
        n_checks++; if (b0.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got=%h exp=00", b0.out_data); end
        n_checks++; if (b0.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got=%b exp=0", b0.out_last); end
        n_checks++; if (b0.grant !== 2'd0) begin n_fail++; $display("FAIL reset_grant got=%0d exp=0", b0.grant); end
        n_checks++; if (b0.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", b0.busy); end
        n_checks++; if (b0.in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0000", b0.in_ready); end
        n_checks++; if (b1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_m1 got=%b exp=0", b1.busy); end
    endtask

    // All four channels valid with single-beat packets: 0,1,2,3,0.
    task automatic test_round_robin();
        do_reset();
        b0.in_data  = 32'h13121110;
        b0.in_last  = 4'b1111;
        b0.in_valid = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            step();
            n_checks++; if (b0.busy !== 1'b1) begin n_fail++; $display("FAIL rr_busy[%0d] got=%b exp=1", j, b0.busy); end
            n_checks++; if (b0.grant !== 2'(j % 4)) begin n_fail++; $display("FAIL rr_grant[%0d] got=%0d exp=%0d", j, b0.grant, j % 4); end
            n_checks++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_gap_valid[%0d] got=%b exp=0", j, b0.out_valid); end
            step();
            n_checks++; if (b0.out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_out_valid[%0d] got=%b exp=1", j, b0.out_valid); end
            n_checks++; if (b0.out_data !== 8'(8'h10 + (j % 4))) begin n_fail++; $display("FAIL rr_out_data[%0d] got=%h exp=%h", j, b0.out_data, 8'(8'h10 + (j % 4))); end
            n_checks++; if (b0.out_last !== 1'b1) begin n_fail++; $display("FAIL rr_out_last[%0d] got=%b exp=1", j, b0.out_last); end
            n_checks++; if (b0.busy !== 1'b0) begin n_fail++; $display("FAIL rr_busy_end[%0d] got=%b exp=0", j, b0.busy); end
        end
    endtask

    // ch2 3-beat packet while ch0 stays valid; then ch3 and ch0 in turn.
    task automatic test_packet_lock();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'hA0;
        exp_d[1] = 8'hA1;
        exp_d[2] = 8'hA2;
        do_reset();
        b0.in_valid = 4'b0100;
        b0.in_data  = 32'h00A00000;
        step();
        n_checks++; if (b0.grant !== 2'd2) begin n_fail++; $display("FAIL lock_grant got=%0d exp=2", b0.grant); end
        b0.in_valid = 4'b1101;
        b0.in_last  = 4'b1001;
        b0.in_data  = 32'hB0A000C0;
        for (int j = 0; j < 3; j++) begin
            b0.in_data[23:16] = exp_d[j];
            b0.in_last[2]     = (j == 2) ? 1'b1 : 1'b0;
            #1;
            n_checks++; if (b0.in_ready !== 4'b0100) begin n_fail++; $display("FAIL lock_in_ready[%0d] got=%b exp=0100", j, b0.in_ready); end
            step();
            n_checks++; if (b0.out_data !== exp_d[j]) begin n_fail++; $display("FAIL lock_out_data[%0d] got=%h exp=%h", j, b0.out_data, exp_d[j]); end
            n_checks++; if (b0.out_last !== (j == 2)) begin n_fail++; $display("FAIL lock_out_last[%0d] got=%b exp=%b", j, b0.out_last, j == 2); end
            n_checks++; if (b0.out_valid !== 1'b1) begin n_fail++; $display("FAIL lock_out_valid[%0d] got=%b exp=1", j, b0.out_valid); end
        end
        n_checks++; if (b0.busy !== 1'b0) begin n_fail++; $display("FAIL lock_busy_end got=%b exp=0", b0.busy); end
        b0.in_valid = 4'b1001;
        step();
        n_checks++; if (b0.grant !== 2'd3) begin n_fail++; $display("FAIL lock_next_grant got=%0d exp=3", b0.grant); end
        step();
        n_checks++; if (b0.out_data !== 8'hB0) begin n_fail++; $display("FAIL lock_ch3_data got=%h exp=b0", b0.out_data); end
        b0.in_valid = 4'b0001;
        step();
        n_checks++; if (b0.grant !== 2'd0) begin n_fail++; $display("FAIL lock_then_ch0 got=%0d exp=0", b0.grant); end
        step();
        n_checks++; if (b0.out_data !== 8'hC0) begin n_fail++; $display("FAIL lock_ch0_data got=%h exp=c0", b0.out_data); end
    endtask

    // out_ready low for 3 cycles mid-packet on ch1.
    task automatic test_backpressure();
        do_reset();
        b0.in_valid = 4'b0010;
        b0.in_data  = 32'h00003000;
        step();
        step();
        n_checks++; if (b0.out_data !== 8'h30) begin n_fail++; $display("FAIL bp_first got=%h exp=30", b0.out_data); end
        b0.in_data   = 32'h00003100;
        b0.out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            n_checks++; if (b0.in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%b exp=0000", j, b0.in_ready); end
            step();
            n_checks++; if (b0.out_data !== 8'h30 || b0.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold[%0d] got=%h/%b exp=30/1", j, b0.out_data, b0.out_valid); end
        end
        b0.out_ready = 1'b1;
        #1;
        n_checks++; if (b0.in_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_resume_ready got=%b exp=0010", b0.in_ready); end
        for (int j = 1; j < 4; j++) begin
            b0.in_data[15:8] = 8'(8'h30 + j);
            b0.in_last[1]    = (j == 3) ? 1'b1 : 1'b0;
            step();
            n_checks++; if (b0.out_data !== 8'(8'h30 + j) || b0.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_resume[%0d] got=%h/%b exp=%h/1", j, b0.out_data, b0.out_valid, 8'(8'h30 + j)); end
        end
        n_checks++; if (b0.out_last !== 1'b1 || b0.busy !== 1'b0) begin n_fail++; $display("FAIL bp_end got=%b/%b exp=1/0", b0.out_last, b0.busy); end
    endtask

    // Lock ch1, move 2 beats, pulse reset; ch0 must win afterwards.
    task automatic test_reset_mid_packet();
        do_reset();
        b0.in_valid = 4'b0010;
        b0.in_data  = 32'h00005000;
        step();
        step();
        b0.in_data = 32'h00005100;
        step();
        n_checks++; if (b0.out_data !== 8'h51 || b0.busy !== 1'b1) begin n_fail++; $display("FAIL rmp_pre got=%h/%b exp=51/1", b0.out_data, b0.busy); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_checks++; if (b0.out_valid !== 1'b0 || b0.busy !== 1'b0) begin n_fail++; $display("FAIL rmp_flush got=%b/%b exp=0/0", b0.out_valid, b0.busy); end
        n_checks++; if (b0.in_ready !== 4'b0000) begin n_fail++; $display("FAIL rmp_in_ready got=%b exp=0000", b0.in_ready); end
        b0.in_valid = 4'b0011;
        b0.in_last  = 4'b0001;
        b0.in_data  = 32'h00005160;
        step();
        n_checks++; if (b0.grant !== 2'd0 || b0.busy !== 1'b1) begin n_fail++; $display("FAIL rmp_ch0_wins got=%0d/%b exp=0/1", b0.grant, b0.busy); end
        step();
        n_checks++; if (b0.out_data !== 8'h60) begin n_fail++; $display("FAIL rmp_ch0_data got=%h exp=60", b0.out_data); end
    endtask

    // Externally selected arbitration on the MODE 1 instance.
    task automatic test_mode1_select();
        do_reset();
        b1.sel      = 3'd3;
        b1.in_valid = 4'b1000;
        b1.in_data  = 32'hD0000000;
        step();
        n_checks++; if (b1.grant !== 3'd3 || b1.busy !== 1'b1) begin n_fail++; $display("FAIL m1_grant got=%0d/%b exp=3/1", b1.grant, b1.busy); end
        b1.sel      = 3'd0;
        b1.in_valid = 4'b1001;
        #1;
        n_checks++; if (b1.in_ready !== 4'b1000) begin n_fail++; $display("FAIL m1_in_ready got=%b exp=1000", b1.in_ready); end
        step();
        n_checks++; if (b1.out_data !== 8'hD0 || b1.grant !== 3'd3) begin n_fail++; $display("FAIL m1_beat0 got=%h/%0d exp=d0/3", b1.out_data, b1.grant); end
        b1.in_data = 32'hD1000000;
        b1.in_last = 4'b1000;
        step();
        n_checks++; if (b1.out_data !== 8'hD1 || b1.out_last !== 1'b1 || b1.busy !== 1'b0) begin n_fail++; $display("FAIL m1_beat1 got=%h/%b/%b exp=d1/1/0", b1.out_data, b1.out_last, b1.busy); end
        b1.sel      = 3'd5;
        b1.in_valid = 4'b1111;
        for (int j = 0; j < 2; j++) begin
            step();
            n_checks++; if (b1.busy !== 1'b0 || b1.in_ready !== 4'b0000) begin n_fail++; $display("FAIL m1_sel5[%0d] got=%b/%b exp=0/0000", j, b1.busy, b1.in_ready); end
        end
        b1.sel = 3'd0;
        step();
        n_checks++; if (b1.grant !== 3'd0 || b1.busy !== 1'b1) begin n_fail++; $display("FAIL m1_sel0 got=%0d/%b exp=0/1", b1.grant, b1.busy); end
    endtask

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b0;
        n_checks = 0;
        n_fail   = 0;
        clear_inputs();
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_reset_mid_packet();
        test_mode1_select();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, W-bit successor to the 2:1 combinational mux.
- Adds per-channel valid/ready handshake, packet locking on `last`, round-robin or externally selected arbitration, and a registered output stage.
- Sits between multiple producer streams and a single consumer, e.g. merging sensor/UART byte streams onto one bus.

Parameters:
- WIDTH, 8, data bits per channel.
- NCH, 4, number of input channels (>=1).
- SELW, 2, width of sel/grant; 2^SELW >= NCH required.
- MODE, 0, 0 = round-robin arbitration; 1 = channel chosen by sel input.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_data  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NCH  per-channel beat valid.
- in_last  in  NCH  per-channel end-of-packet flag.
- in_ready  out  NCH  per-channel beat accepted.
- sel  in  SELW  requested channel (MODE 1 only; ignored in MODE 0).
- out_data  out  WIDTH  registered output data.
- out_valid  out  1  output beat valid.
- out_last  out  1  output end-of-packet flag.
- out_ready  in  1  consumer accepts beat.
- grant  out  SELW  channel currently locked.
- busy  out  1  high while a packet is locked.

Behaviour:
- Reset (rst_n low at a clock edge):
  - Registered outputs: out_valid=0, out_data=0, out_last=0, grant=0, busy=0.
  - Internal state: state=IDLE; rr pointer last_grant=NCH-1, so channel 0 wins first.
  - Reset mid-packet discards the held beat and the lock; no partial state survives.
- Definitions:
  - Transfer on input i: in_valid[i] && in_ready[i] at a clock edge.
  - Output transfer: out_valid && out_ready.
  - accept = !out_valid || out_ready.
- FSM, two states:
  - IDLE:
    - in_ready = 0 on all channels.
    - MODE 0: candidate = first i with in_valid[i]=1, searching from last_grant+1 upward and wrapping modulo NCH.
    - MODE 1: candidate = sel, only if sel < NCH and in_valid[sel]=1. sel >= NCH means no grant; stay IDLE.
    - If a candidate exists: grant<=candidate, busy<=1, go to LOCKED. This costs one arbitration cycle; no data moves.
  - LOCKED:
    - in_ready[grant] = accept; every other in_ready = 0.
    - On an input transfer: out_data<=in_data[grant], out_last<=in_last[grant], out_valid<=1.
    - If that transfer has in_last=1: last_grant<=grant, busy<=0, go to IDLE.
    - sel changes and other channels' valid are ignored until the packet ends.
- Output register:
  - If out_valid && out_ready with no new input transfer, out_valid<=0.
  - Simultaneous drain and load in the same cycle is allowed, giving full throughput of 1 beat/clk inside a packet.
  - out_data/out_last hold stable while out_valid && !out_ready (backpressure).
- Latency:
  - First beat of a packet: 2 clocks from in_valid rising in IDLE to out_valid.
  - Later beats: 1 clock.
  - Inter-packet gap: 1 arbitration cycle.
- in_ready is combinational from out_valid/out_ready/state. It never depends on in_valid of the same channel.
- NCH=1: always grants channel 0; round-robin degenerates cleanly.
- A single-beat packet (in_last=1 on the first beat) returns to IDLE after one transfer.
- Behaviour for in_valid deasserting mid-packet without a transfer: the lock is held and the block waits indefinitely.

Test Plan:
- Reset mid-packet:
  - Stimulus: MODE 0, lock channel 1, transfer 2 beats, assert rst_n=0 for 1 cycle.
  - Required response: out_valid=0, busy=0, in_ready=0000 next cycle; ch0 wins the next arbitration.
- Round-robin fairness:
  - Stimulus: MODE 0, NCH=4, all channels valid, each sending 1-beat packets with data=0x10+i.
  - Required response: grant order 0,1,2,3,0; out_data 0x10,0x11,0x12,0x13,0x10, one beat every 2 clocks.
- Packet lock:
  - Stimulus: ch2 sends a 3-beat packet (0xA0,0xA1,0xA2 last) while ch0 is valid throughout.
  - Required response: out_data A0,A1,A2 on consecutive clocks with out_last only on A2; in_ready[0]=0 throughout; ch3 then ch0 arbitrated next.
- Backpressure:
  - Stimulus: hold out_ready=0 for 3 cycles mid-packet.
  - Required response: out_data held stable, in_ready[grant]=0, no beat lost or duplicated; resumes at 1 beat/clk once out_ready=1.
- MODE 1 select:
  - Stimulus: sel=3 with in_valid=1000, 2-beat packet; sel switched to 0 mid-packet.
  - Required response: packet completes from ch3, grant=3. With sel=5 (SELW=3, NCH=4) and all channels valid, the block stays IDLE with busy=0.
